// File: rtl/rf_ctrl_pkg.sv
// Shared types and default sizing for the register-file write arbiter.
package rf_ctrl_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    ARB   = 1'b1
  } rf_state_t;

  localparam int N_DEF = 4;
  localparam int R_DEF = 256;
  localparam int W_DEF = 32;
  localparam int L_DEF = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first valid requester after the last
// winner, with wrap-around.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_valid,
  input  logic [IW-1:0] i_last_grant,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_grant_idx,
  output logic          o_any_grant
);

  logic [IW-1:0] w_scan;

  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    o_any_grant = 1'b0;
    w_scan      = '0;
    for (int off = 1; off <= N; off++) begin
      w_scan = IW'((int'(i_last_grant) + off) % N);
      if (!o_any_grant && i_valid[w_scan]) begin
        o_grant[w_scan] = 1'b1;
        o_grant_idx     = w_scan;
        o_any_grant     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Owns the register-file write port: zero sweep after reset or clear, then
// round-robin sharing among N valid/ready requesters.
//
// state | meaning
// ------+--------------------------------------------------------------
// CLEAR | writing zeros to addresses 0..R-1, requesters held off
// ARB   | register file initialised, one granted write per cycle
module rf_write_arbiter
  import rf_ctrl_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int R = R_DEF,
  parameter int W = W_DEF,
  parameter int L = L_DEF
) (
  input  logic           clk,
  input  logic           rst_n_i,
  input  logic           clear_i,
  input  logic [N-1:0]   req_valid_i,
  input  logic [N*L-1:0] req_addr_i,
  input  logic [N*W-1:0] req_data_i,
  output logic [N-1:0]   req_ready_o,
  output logic           init_done_o,
  output logic           wen_o,
  output logic [L-1:0]   wa_o,
  output logic [W-1:0]   wd_o
);

  localparam int IW = $clog2(N);

  rf_state_t     r_state;
  logic [L-1:0]  r_cnt;
  logic [IW-1:0] r_last_grant;
  logic          r_init_done;
  logic          r_wen;
  logic [L-1:0]  r_wa;
  logic [W-1:0]  r_wd;

  logic [N-1:0]  w_grant;
  logic [IW-1:0] w_grant_idx;
  logic          w_any_grant;
  logic          w_xfer;
  logic [L-1:0]  w_sel_addr;
  logic [W-1:0]  w_sel_data;

  rr_arbiter #(
    .N  (N),
    .IW (IW)
  ) u_rr_arbiter (
    .i_valid      (req_valid_i),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant),
    .o_grant_idx  (w_grant_idx),
    .o_any_grant  (w_any_grant)
  );

  // A pending clear suppresses the grant in the same cycle.
  assign req_ready_o = (r_state == ARB && !clear_i) ? w_grant : '0;
  assign w_xfer      = (r_state == ARB) && !clear_i && w_any_grant;

  always_comb begin
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int k = 0; k < N; k++) begin
      if (w_grant[k]) begin
        w_sel_addr = req_addr_i[k*L +: L];
        w_sel_data = req_data_i[k*W +: W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n_i) begin
      r_state      <= CLEAR;
      r_cnt        <= '0;
      r_last_grant <= IW'(N - 1);
      r_init_done  <= 1'b0;
      r_wen        <= 1'b0;
      r_wa         <= '0;
      r_wd         <= '0;
    end else begin
      case (r_state)
        CLEAR: begin
          r_wen <= 1'b1;
          r_wa  <= r_cnt;
          r_wd  <= '0;
          if (r_cnt == L'(R - 1)) begin
            r_state     <= ARB;
            r_init_done <= 1'b1;
            r_cnt       <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ARB: begin
          if (clear_i) begin
            r_state     <= CLEAR;
            r_cnt       <= '0;
            r_init_done <= 1'b0;
            r_wen       <= 1'b0;
          end else if (w_xfer) begin
            r_wen        <= 1'b1;
            r_wa         <= w_sel_addr;
            r_wd         <= w_sel_data;
            r_last_grant <= w_grant_idx;
          end else begin
            r_wen <= 1'b0;
          end
        end
      endcase
    end
  end

  assign init_done_o = r_init_done;
  assign wen_o       = r_wen;
  assign wa_o        = r_wa;
  assign wd_o        = r_wd;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed scenarios plus randomized traffic
// checked against a priority-list arbiter model and a register-file image.
module tb_rf_write_arbiter;

  localparam int N = 4;
  localparam int R = 256;
  localparam int W = 32;
  localparam int L = 8;

  logic           clk = 1'b0;
  logic           rst_n_i;
  logic           clear_i;
  logic [N-1:0]   req_valid_i;
  logic [N*L-1:0] req_addr_i;
  logic [N*W-1:0] req_data_i;
  logic [N-1:0]   req_ready_o;
  logic           init_done_o;
  logic           wen_o;
  logic [L-1:0]   wa_o;
  logic [W-1:0]   wd_o;

  logic [L-1:0] a_addr [N];
  logic [W-1:0] a_data [N];
  logic [W-1:0] dut_rf [R];
  logic [W-1:0] exp_rf [R];

  int n_vec = 0;
  int n_err = 0;
  int m_last;

  always #5 clk = ~clk;

  always_comb begin
    req_addr_i = '0;
    req_data_i = '0;
    for (int k = 0; k < N; k++) begin
      req_addr_i[k*L +: L] = a_addr[k];
      req_data_i[k*W +: W] = a_data[k];
    end
  end

  always @(posedge clk) if (wen_o === 1'b1) dut_rf[wa_o] <= wd_o;

  rf_write_arbiter #(.N(N), .R(R), .W(W), .L(L)) dut (
    .clk         (clk),
    .rst_n_i     (rst_n_i),
    .clear_i     (clear_i),
    .req_valid_i (req_valid_i),
    .req_addr_i  (req_addr_i),
    .req_data_i  (req_data_i),
    .req_ready_o (req_ready_o),
    .init_done_o (init_done_o),
    .wen_o       (wen_o),
    .wa_o        (wa_o),
    .wd_o        (wd_o)
  );

  // Priority list starts just after the previous winner and wraps around.
  function automatic int ref_winner(input logic [N-1:0] v, input int last);
    int order [N];
    for (int i = 0; i < N; i++) order[i] = (last + 1 + i) % N;
    foreach (order[i]) if (v[order[i]]) return order[i];
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int w);
    return (w < 0) ? '0 : (N'(1) << w);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_sweep(output int nw, output int nbad);
    nw = 0;
    nbad = 0;
    for (int c = 0; c < R + 8; c++) begin
      tick();
      if (wen_o === 1'b1 && wd_o === '0 && wa_o === L'(nw)) nw++;
      else nbad++;
      if (init_done_o === 1'b1) break;
      if (req_ready_o !== '0) nbad++;
    end
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0;
    clear_i = 1'b0;
    req_valid_i = '1;
    tick();
    tick();
    #1;
    n_vec++;
    if ({req_ready_o, init_done_o, wen_o, wa_o, wd_o} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got rdy=%b init=%b wen=%b wa=%h wd=%h, expected all zero",
               req_ready_o, init_done_o, wen_o, wa_o, wd_o);
    end
    req_valid_i = '0;
    rst_n_i = 1'b1;
    for (int e = 1; e <= R; e++) begin
      tick();
      n_vec++;
      if (wen_o !== 1'b1 || wa_o !== L'(e - 1) || wd_o !== '0 || req_ready_o !== '0) begin
        n_err++;
        $display("FAIL sweep_edge%0d: got wen=%b wa=%0d wd=%h rdy=%b, expected wen=1 wa=%0d wd=0 rdy=0",
                 e, wen_o, wa_o, wd_o, req_ready_o, e - 1);
      end
      if (e >= R - 1) begin
        n_vec++;
        if (init_done_o !== (e == R)) begin
          n_err++;
          $display("FAIL init_done_edge%0d: got %b expected %b", e, init_done_o, (e == R));
        end
      end
    end
    tick();
    n_vec++;
    if (wen_o !== 1'b0 || init_done_o !== 1'b1) begin
      n_err++;
      $display("FAIL after_sweep: got wen=%b init=%b, expected wen=0 init=1", wen_o, init_done_o);
    end
    m_last = N - 1;
  endtask

  task automatic test_all_valid();
    logic [N-1:0] exp_rdy;
    for (int k = 0; k < N; k++) begin
      a_addr[k] = L'(8'h20 + k);
      a_data[k] = $urandom();
    end
    req_valid_i = '1;
    for (int i = 0; i < 8; i++) begin
      exp_rdy = N'(1) << (i % N);
      #1;
      n_vec++;
      if (req_ready_o !== exp_rdy) begin
        n_err++;
        $display("FAIL all_valid_rdy%0d: got %b expected %b", i, req_ready_o, exp_rdy);
      end
      tick();
      n_vec++;
      if (wen_o !== 1'b1 || wa_o !== a_addr[i % N] || wd_o !== a_data[i % N]) begin
        n_err++;
        $display("FAIL all_valid_write%0d: got wen=%b wa=%h wd=%h expected wen=1 wa=%h wd=%h",
                 i, wen_o, wa_o, wd_o, a_addr[i % N], a_data[i % N]);
      end
      m_last = i % N;
    end
    req_valid_i = '0;
  endtask

  task automatic test_single();
    a_addr[2] = 8'h05;
    a_data[2] = 32'hDEADBEEF;
    req_valid_i = 4'b0100;
    #1;
    n_vec++;
    if (req_ready_o !== onehot(ref_winner(req_valid_i, m_last))) begin
      n_err++;
      $display("FAIL single_rdy: got %b expected 0100", req_ready_o);
    end
    tick();
    req_valid_i = '0;
    m_last = 2;
    n_vec++;
    if (wen_o !== 1'b1 || wa_o !== 8'h05 || wd_o !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL single_write: got wen=%b wa=%h wd=%h expected 1 05 deadbeef", wen_o, wa_o, wd_o);
    end
    tick();
    n_vec++;
    if (wen_o !== 1'b0 || wa_o !== 8'h05 || wd_o !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL single_idle_hold: got wen=%b wa=%h wd=%h expected 0 05 deadbeef", wen_o, wa_o, wd_o);
    end
  endtask

  task automatic test_collision();
    a_addr[1] = 8'h30;
    a_data[1] = 32'h99;
    req_valid_i = 4'b0010;
    #1;
    n_vec++;
    if (req_ready_o !== 4'b0010) begin
      n_err++;
      $display("FAIL coll_setup_rdy: got %b expected 0010", req_ready_o);
    end
    tick();
    req_valid_i = '0;
    m_last = 1;
    a_addr[1] = 8'h10;
    a_data[1] = 32'h11;
    a_addr[3] = 8'h10;
    a_data[3] = 32'h33;
    req_valid_i = 4'b1010;
    #1;
    n_vec++;
    if (req_ready_o !== 4'b1000) begin
      n_err++;
      $display("FAIL coll_first_rdy: got %b expected 1000", req_ready_o);
    end
    tick();
    req_valid_i = 4'b0010;
    n_vec++;
    if (wen_o !== 1'b1 || wa_o !== 8'h10 || wd_o !== 32'h33) begin
      n_err++;
      $display("FAIL coll_first_write: got wen=%b wa=%h wd=%h expected 1 10 33", wen_o, wa_o, wd_o);
    end
    #1;
    n_vec++;
    if (req_ready_o !== 4'b0010) begin
      n_err++;
      $display("FAIL coll_second_rdy: got %b expected 0010", req_ready_o);
    end
    tick();
    req_valid_i = '0;
    n_vec++;
    if (wen_o !== 1'b1 || wa_o !== 8'h10 || wd_o !== 32'h11) begin
      n_err++;
      $display("FAIL coll_second_write: got wen=%b wa=%h wd=%h expected 1 10 11", wen_o, wa_o, wd_o);
    end
    tick();
    m_last = 1;
    n_vec++;
    if (dut_rf[16] !== 32'h11) begin
      n_err++;
      $display("FAIL coll_last_wins: got rf[16]=%h expected 00000011", dut_rf[16]);
    end
  endtask

  task automatic test_clear();
    int nw, nbad;
    a_addr[0] = 8'h44;
    a_data[0] = 32'h0000ABCD;
    req_valid_i = 4'b0001;
    clear_i = 1'b1;
    #1;
    n_vec++;
    if (req_ready_o !== '0) begin
      n_err++;
      $display("FAIL clear_rdy: got %b expected 0000", req_ready_o);
    end
    tick();
    clear_i = 1'b0;
    n_vec++;
    if (init_done_o !== 1'b0 || wen_o !== 1'b0) begin
      n_err++;
      $display("FAIL clear_entry: got init=%b wen=%b expected 0 0", init_done_o, wen_o);
    end
    run_sweep(nw, nbad);
    n_vec++;
    if (nw !== R || nbad !== 0 || init_done_o !== 1'b1) begin
      n_err++;
      $display("FAIL clear_sweep: got writes=%0d bad=%0d init=%b expected %0d 0 1", nw, nbad, init_done_o, R);
    end
    n_vec++;
    if (dut_rf[16] !== '0) begin
      n_err++;
      $display("FAIL clear_rf16: got %h expected 0", dut_rf[16]);
    end
    #1;
    n_vec++;
    if (req_ready_o !== onehot(ref_winner(req_valid_i, m_last))) begin
      n_err++;
      $display("FAIL clear_then_grant_rdy: got %b expected 0001", req_ready_o);
    end
    tick();
    req_valid_i = '0;
    m_last = 0;
    n_vec++;
    if (wen_o !== 1'b1 || wa_o !== 8'h44 || wd_o !== 32'h0000ABCD) begin
      n_err++;
      $display("FAIL clear_then_grant_write: got wen=%b wa=%h wd=%h expected 1 44 0000abcd", wen_o, wa_o, wd_o);
    end
  endtask

  task automatic test_reset_mid_sweep();
    int nw, nbad;
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    for (int i = 0; i < 100; i++) tick();
    n_vec++;
    if (wa_o !== 8'd99 || wen_o !== 1'b1) begin
      n_err++;
      $display("FAIL mid_sweep_pos: got wen=%b wa=%0d expected 1 99", wen_o, wa_o);
    end
    rst_n_i = 1'b0;
    req_valid_i = '1;
    tick();
    n_vec++;
    if ({req_ready_o, init_done_o, wen_o, wa_o, wd_o} !== '0) begin
      n_err++;
      $display("FAIL mid_reset_outputs: got rdy=%b init=%b wen=%b wa=%h wd=%h expected all zero",
               req_ready_o, init_done_o, wen_o, wa_o, wd_o);
    end
    rst_n_i = 1'b1;
    req_valid_i = '0;
    run_sweep(nw, nbad);
    n_vec++;
    if (nw !== R || nbad !== 0 || init_done_o !== 1'b1) begin
      n_err++;
      $display("FAIL mid_reset_sweep: got writes=%0d bad=%0d init=%b expected %0d 0 1", nw, nbad, init_done_o, R);
    end
    m_last = N - 1;
    req_valid_i = '1;
    #1;
    n_vec++;
    if (req_ready_o !== onehot(ref_winner(req_valid_i, m_last))) begin
      n_err++;
      $display("FAIL mid_reset_priority: got %b expected 0001", req_ready_o);
    end
    tick();
    req_valid_i = '0;
    m_last = 0;
  endtask

  task automatic test_random();
    logic [N-1:0] pend;
    logic [N-1:0] exp_rdy;
    int w;
    pend = '0;
    for (int a = 0; a < 16; a++) exp_rf[a] = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int k = 0; k < N; k++) begin
        if (!pend[k] && $urandom_range(0, 1) == 1) begin
          pend[k] = 1'b1;
          a_addr[k] = L'($urandom_range(0, 15));
          a_data[k] = $urandom();
        end
      end
      req_valid_i = pend;
      w = ref_winner(pend, m_last);
      exp_rdy = onehot(w);
      #1;
      n_vec++;
      if (req_ready_o !== exp_rdy) begin
        n_err++;
        $display("FAIL rand_rdy%0d: got %b expected %b", cyc, req_ready_o, exp_rdy);
      end
      tick();
      n_vec++;
      if (w >= 0) begin
        if (wen_o !== 1'b1 || wa_o !== a_addr[w] || wd_o !== a_data[w]) begin
          n_err++;
          $display("FAIL rand_write%0d: got wen=%b wa=%h wd=%h expected 1 %h %h",
                   cyc, wen_o, wa_o, wd_o, a_addr[w], a_data[w]);
        end
        exp_rf[a_addr[w]] = a_data[w];
        pend[w] = 1'b0;
        m_last = w;
      end else if (wen_o !== 1'b0) begin
        n_err++;
        $display("FAIL rand_idle%0d: got wen=%b expected 0", cyc, wen_o);
      end
    end
    req_valid_i = '0;
    tick();
    for (int a = 0; a < 16; a++) begin
      n_vec++;
      if (dut_rf[a] !== exp_rf[a]) begin
        n_err++;
        $display("FAIL rand_rf%0d: got %h expected %h", a, dut_rf[a], exp_rf[a]);
      end
    end
  endtask

  initial begin
    rst_n_i = 1'b0;
    clear_i = 1'b0;
    req_valid_i = '0;
    for (int k = 0; k < N; k++) begin
      a_addr[k] = '0;
      a_data[k] = '0;
    end
    test_reset();
    test_all_valid();
    test_single();
    test_collision();
    test_clear();
    test_reset_mid_sweep();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, n_err=%0d", n_err);
    $fatal(1, "timeout");
  end

endmodule
